// File: rtl/pkt_rx_parser_if.sv
// Purpose: byte-bus, buffer read port and status/time outputs of the frame receiver.
// Latency: n/a (signal bundle only).
// Backpressure: none; the byte bus is free-running at one byte per clock.
interface pkt_rx_parser_if;
    logic        fs1;
    logic [7:0]  ppi;
    logic [7:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        busy;
    logic        frame_ok;
    logic        crc_err;
    logic        hdr_err;
    logic        frame_valid;
    logic [7:0]  t_day;
    logic [7:0]  t_hour;
    logic [7:0]  t_min;
    logic [7:0]  t_sec;
    logic [15:0] t_ms;

    // Source of frames and reader of results
    modport master (
        output fs1, ppi, rd_addr,
        input  rd_data, busy, frame_ok, crc_err, hdr_err, frame_valid,
        input  t_day, t_hour, t_min, t_sec, t_ms
    );

    // The parser itself
    modport slave (
        input  fs1, ppi, rd_addr,
        output rd_data, busy, frame_ok, crc_err, hdr_err, frame_valid,
        output t_day, t_hour, t_min, t_sec, t_ms
    );
endinterface

// File: rtl/pkt_rx_parser.sv
// Purpose: receive a fixed-length framed byte stream, buffer it, verify header/address/checksum, decode time fields.
// Latency: status pulse one clock after the checksum byte; rd_data one clock after rd_addr.
// Backpressure: none; bytes are taken every clock, fs1 re-assertion aborts the frame in flight.
module pkt_rx_parser #(
    parameter logic [7:0] MY_ADDR   = 8'h01,
    parameter int         FRAME_LEN = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    pkt_rx_parser_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RECV  = 2'd2,
        CHECK = 2'd3
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);
    localparam logic [7:0] HDR_BYTE = 8'hAA;

    state_t      state_q;
    logic [7:0]  idx_q;
    logic [7:0]  sum_q;
    logic [7:0]  sum_d;
    logic        hdr_bad_q;
    logic        cks_ok_q;

    logic        busy_q;
    logic        frame_ok_q;
    logic        crc_err_q;
    logic        hdr_err_q;
    logic        frame_valid_q;
    logic [7:0]  t_day_q;
    logic [7:0]  t_hour_q;
    logic [7:0]  t_min_q;
    logic [7:0]  t_sec_q;
    logic [15:0] t_ms_q;
    logic [7:0]  rd_data_q;

    // Frame buffer plus a shadow copy of the time-carrying bytes 2..12, so the
    // decode can read all of them in one cycle without a wide buffer read.
    logic [7:0]  mem [256];
    logic [7:0]  tf_q [2:12];

    logic        wr_en;
    logic [7:0]  wr_addr;

    // Running checksum of the byte currently on the bus
    always_comb begin
        sum_d = sum_q + bus.ppi;
    end

    // Buffer write: byte 0 is taken on ARM exit, later bytes in RECV; fs1 blocks writes
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = 8'h00;
        if (!bus.fs1) begin
            if (state_q == ARM) begin
                wr_en   = 1'b1;
                wr_addr = 8'h00;
            end else if (state_q == RECV) begin
                wr_en   = 1'b1;
                wr_addr = idx_q;
            end
        end
    end

    // Buffer and time-byte shadow storage; contents are not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= bus.ppi;
        end
        for (int k = 2; k <= 12; k++) begin
            if (wr_en && (wr_addr == 8'(k))) begin
                tf_q[k] <= bus.ppi;
            end
        end
    end

    // Registered read port, usable in any state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= 8'h00;
        end else begin
            rd_data_q <= mem[bus.rd_addr];
        end
    end

    // Frame FSM with registered status pulses, frame_valid level and time decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= 8'h00;
            sum_q         <= 8'h00;
            hdr_bad_q     <= 1'b0;
            cks_ok_q      <= 1'b0;
            busy_q        <= 1'b0;
            frame_ok_q    <= 1'b0;
            crc_err_q     <= 1'b0;
            hdr_err_q     <= 1'b0;
            frame_valid_q <= 1'b0;
            t_day_q       <= 8'h00;
            t_hour_q      <= 8'h00;
            t_min_q       <= 8'h00;
            t_sec_q       <= 8'h00;
            t_ms_q        <= 16'h0000;
        end else begin
            frame_ok_q <= 1'b0;
            crc_err_q  <= 1'b0;
            hdr_err_q  <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (bus.fs1) begin
                        state_q       <= ARM;
                        busy_q        <= 1'b1;
                        frame_valid_q <= 1'b0;
                    end
                end

                ARM: begin
                    // The first clock after fs1 drops carries byte 0
                    if (!bus.fs1) begin
                        sum_q     <= bus.ppi;
                        idx_q     <= 8'h01;
                        hdr_bad_q <= (bus.ppi != HDR_BYTE);
                        state_q   <= RECV;
                    end
                end

                RECV: begin
                    if (bus.fs1) begin
                        // Restart: drop this frame without any status pulse
                        state_q <= ARM;
                        idx_q   <= 8'h00;
                    end else if ((idx_q == 8'h01) && hdr_bad_q) begin
                        hdr_err_q <= 1'b1;
                        busy_q    <= 1'b0;
                        idx_q     <= 8'h00;
                        state_q   <= IDLE;
                    end else if ((idx_q == 8'h01) && (bus.ppi != MY_ADDR)) begin
                        // Frame for another receiver: leave quietly
                        busy_q  <= 1'b0;
                        idx_q   <= 8'h00;
                        state_q <= IDLE;
                    end else if (idx_q == LAST_IDX) begin
                        // Checksum byte: compare only, idx holds so it never wraps
                        cks_ok_q <= (bus.ppi == sum_q);
                        state_q  <= CHECK;
                    end else begin
                        sum_q <= sum_d;
                        idx_q <= idx_q + 8'h01;
                    end
                end

                CHECK: begin
                    idx_q <= 8'h00;
                    if (bus.fs1) begin
                        state_q <= ARM;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                        if (cks_ok_q) begin
                            frame_ok_q    <= 1'b1;
                            frame_valid_q <= 1'b1;
                            if (tf_q[2] == 8'h30) t_day_q  <= tf_q[3];
                            if (tf_q[4] == 8'h31) t_hour_q <= tf_q[5];
                            if (tf_q[6] == 8'h32) t_min_q  <= tf_q[7];
                            if (tf_q[8] == 8'h33) t_sec_q  <= tf_q[9];
                            if (tf_q[10] == 8'h34) t_ms_q  <= {tf_q[11], tf_q[12]};
                        end else begin
                            crc_err_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.busy        = busy_q;
    assign bus.frame_ok    = frame_ok_q;
    assign bus.crc_err     = crc_err_q;
    assign bus.hdr_err     = hdr_err_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.t_day       = t_day_q;
    assign bus.t_hour      = t_hour_q;
    assign bus.t_min       = t_min_q;
    assign bus.t_sec       = t_sec_q;
    assign bus.t_ms        = t_ms_q;

endmodule

// File: tb/tb_pkt_rx_parser.sv
// Purpose: directed frames against pkt_rx_parser with a pulse scoreboard.
// Latency: pulses expected one clock after the checksum or the byte after byte 0.
// Backpressure: none; frames are streamed one byte per clock.
module tb_pkt_rx_parser;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    pkt_rx_parser_if bus ();

    pkt_rx_parser #(
        .MY_ADDR   (8'h01),
        .FRAME_LEN (256)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam int K_OK  = 1;
    localparam int K_CRC = 2;
    localparam int K_HDR = 3;

    // Frame heads, bytes 0..12 most significant first
    localparam logic [103:0] HEAD_A = 104'hAA_01_30_00_31_0B_32_00_33_00_34_01_F4;
    localparam logic [103:0] HEAD_B = 104'hAA_01_30_05_31_0C_32_1E_33_2D_34_03_E7;
    localparam logic [103:0] HEAD_C = 104'hAA_01_30_07_99_22_00_00_00_00_00_00_00;
    localparam logic [103:0] HEAD_H = 104'h55_01_30_00_31_0B_32_00_33_00_34_01_F4;
    localparam logic [103:0] HEAD_N = 104'hAA_02_30_00_31_0B_32_00_33_00_34_01_F4;

    typedef struct {
        int          kind;
        logic [7:0]  day;
        logic [7:0]  hour;
        logic [7:0]  mn;
        logic [7:0]  sec;
        logic [15:0] ms;
        logic        fv;
    } exp_t;

    exp_t        sb_q [$];
    int          checks = 0;
    int          errors = 0;

    logic [7:0]  m_day, m_hour, m_min, m_sec;
    logic [15:0] m_ms;
    logic [7:0]  fr [256];

    int          mon_kind;
    exp_t        mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic fv);
        exp_t e;
        e.kind = kind;
        e.day  = m_day;
        e.hour = m_hour;
        e.mn   = m_min;
        e.sec  = m_sec;
        e.ms   = m_ms;
        e.fv   = fv;
        sb_q.push_back(e);
    endtask

    task automatic make_frame(input logic [103:0] head, input logic [7:0] cks);
        for (int i = 0; i < 256; i++) fr[i] = 8'h00;
        for (int i = 0; i < 13; i++) fr[i] = head[8*(12-i) +: 8];
        fr[255] = cks;
    endtask

    // fs1 high for two clocks, then bytes 0..n-1
    task automatic send(input int n);
        bus.fs1 = 1'b1;
        bus.ppi = 8'hFF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.fs1 = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.ppi = fr[i];
            @(posedge clk); #1;
        end
    endtask

    task automatic finish_frame(input string name);
        bus.ppi = 8'hFF;
        @(posedge clk); #1;
        chk({name, "_busy_after"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic idle(input int n);
        bus.fs1 = 1'b0;
        bus.ppi = 8'hFF;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic rd(input string name, input logic [7:0] a, input logic [7:0] exp);
        bus.rd_addr = a;
        @(posedge clk); #1;
        chk(name, 32'(bus.rd_data), 32'(exp));
    endtask

    task automatic check_zero(input string p);
        chk({p, "_busy"},        32'(bus.busy),        32'd0);
        chk({p, "_frame_ok"},    32'(bus.frame_ok),    32'd0);
        chk({p, "_crc_err"},     32'(bus.crc_err),     32'd0);
        chk({p, "_hdr_err"},     32'(bus.hdr_err),     32'd0);
        chk({p, "_frame_valid"}, 32'(bus.frame_valid), 32'd0);
        chk({p, "_t_day"},       32'(bus.t_day),       32'd0);
        chk({p, "_t_hour"},      32'(bus.t_hour),      32'd0);
        chk({p, "_t_min"},       32'(bus.t_min),       32'd0);
        chk({p, "_t_sec"},       32'(bus.t_sec),       32'd0);
        chk({p, "_t_ms"},        32'(bus.t_ms),        32'd0);
        chk({p, "_rd_data"},     32'(bus.rd_data),     32'd0);
    endtask

    // Scoreboard monitor: every status pulse must match the next expectation
    always @(negedge clk) begin
        if (bus.frame_ok || bus.crc_err || bus.hdr_err) begin
            mon_kind = bus.frame_ok ? K_OK : (bus.crc_err ? K_CRC : K_HDR);
            chk("pulse_exclusive",
                32'(bus.frame_ok) + 32'(bus.crc_err) + 32'(bus.hdr_err), 32'd1);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse actual=kind%0d required=no_pulse", mon_kind);
            end else begin
                mon_e = sb_q.pop_front();
                chk("pulse_kind",   32'(mon_kind),        32'(mon_e.kind));
                chk("pulse_fv",     32'(bus.frame_valid), 32'(mon_e.fv));
                chk("pulse_busy",   32'(bus.busy),        32'd0);
                chk("pulse_t_day",  32'(bus.t_day),       32'(mon_e.day));
                chk("pulse_t_hour", 32'(bus.t_hour),      32'(mon_e.hour));
                chk("pulse_t_min",  32'(bus.t_min),       32'(mon_e.mn));
                chk("pulse_t_sec",  32'(bus.t_sec),       32'(mon_e.sec));
                chk("pulse_t_ms",   32'(bus.t_ms),        32'(mon_e.ms));
            end
        end
    end

    initial begin
        bus.fs1     = 1'b0;
        bus.ppi     = 8'hFF;
        bus.rd_addr = 8'h00;
        m_day  = 8'h00;
        m_hour = 8'h00;
        m_min  = 8'h00;
        m_sec  = 8'h00;
        m_ms   = 16'h0000;

        // Reset state
        #2 rst_n = 1'b0;
        #1 check_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(3);

        // Good frame A: checksum 0xA5
        make_frame(HEAD_A, 8'hA5);
        m_hour = 8'h0B;
        m_ms   = 16'h01F4;
        push(K_OK, 1'b1);
        send(256);
        chk("A_busy_in_frame", 32'(bus.busy), 32'd1);
        finish_frame("A");
        idle(3);
        chk("A_frame_valid", 32'(bus.frame_valid), 32'd1);
        rd("A_rd5", 8'd5, 8'h0B);
        rd("A_rd12", 8'd12, 8'hF4);
        rd("A_rd255", 8'd255, 8'hA5);

        // Same frame, checksum off by one bit
        make_frame(HEAD_A, 8'hA4);
        push(K_CRC, 1'b0);
        send(256);
        finish_frame("crc");
        idle(3);
        chk("crc_frame_valid", 32'(bus.frame_valid), 32'd0);

        // Bad header byte
        make_frame(HEAD_H, 8'hA5);
        push(K_HDR, 1'b0);
        send(1);
        chk("hdr_pre_pulse", 32'(bus.hdr_err), 32'd0);
        chk("hdr_pre_busy", 32'(bus.busy), 32'd1);
        bus.ppi = fr[1];
        @(posedge clk); #1;
        chk("hdr_pulse", 32'(bus.hdr_err), 32'd1);
        chk("hdr_busy", 32'(bus.busy), 32'd0);
        idle(4);

        // Foreign address: silent drop, then a good frame is accepted
        make_frame(HEAD_N, 8'hA5);
        send(2);
        chk("addr_busy", 32'(bus.busy), 32'd0);
        idle(5);
        chk("addr_frame_valid", 32'(bus.frame_valid), 32'd0);
        make_frame(HEAD_A, 8'hA5);
        push(K_OK, 1'b1);
        send(256);
        finish_frame("addr_A");
        idle(3);
        chk("addr_A_frame_valid", 32'(bus.frame_valid), 32'd1);

        // Restart at byte 100, then good frame B: checksum 0xEB
        make_frame(HEAD_A, 8'hA5);
        send(100);
        make_frame(HEAD_B, 8'hEB);
        m_day  = 8'h05;
        m_hour = 8'h0C;
        m_min  = 8'h1E;
        m_sec  = 8'h2D;
        m_ms   = 16'h03E7;
        push(K_OK, 1'b1);
        send(256);
        finish_frame("B");
        idle(3);
        rd("B_rd3", 8'd3, 8'h05);
        rd("B_rd11", 8'd11, 8'h03);
        rd("B_rd255", 8'd255, 8'hEB);

        // Reset at byte 50, stray bytes without fs1, then frame C: checksum 0x9D
        make_frame(HEAD_A, 8'hA5);
        send(50);
        rst_n = 1'b0;
        #1 check_zero("rst_mid");
        m_day  = 8'h00;
        m_hour = 8'h00;
        m_min  = 8'h00;
        m_sec  = 8'h00;
        m_ms   = 16'h0000;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.ppi = 8'hAA;
        repeat (20) begin
            @(posedge clk); #1;
        end
        chk("rst_no_restart_busy", 32'(bus.busy), 32'd0);
        idle(3);
        make_frame(HEAD_C, 8'h9D);
        m_day = 8'h07;
        push(K_OK, 1'b1);
        send(256);
        finish_frame("C");
        idle(5);

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
